// File: rtl/psrand_pkg.sv
// Shared definitions for the xorshift32 pseudo-random stream: step function,
// shift constants, restart mode code and checker state encoding.
package psrand_pkg;

  localparam int         SH_A      = 13;
  localparam int         SH_B      = 7;
  localparam int         SH_C      = 11;
  localparam logic [3:0] MODE_RAND = 4'b0011;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} psrand_chk_st_t;

  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/psrand_step.sv
// Combinational single xorshift32 step; the generator-side model uses the same block.
module psrand_step
  import psrand_pkg::*;
(
  input  logic [31:0] cur,
  output logic [31:0] nxt
);

  assign nxt = xorshift32_step(cur);

endmodule

// File: rtl/psrand_chk.sv
// Receive-side xorshift32 checker: hunts, verifies, then flywheels on the stream
// and counts word errors. Optional macro PSRAND_CHK_BITCNT_EN adds a bit-error counter.
module psrand_chk
  import psrand_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [3:0]       mode_in,
  input  logic             data_vld_in,
  input  logic [31:0]      data_in,
  output logic             locked_out,
  output logic             lock_pls_out,
  output logic             err_pls_out,
  output logic [ERR_W-1:0] err_cnt_out
`ifdef PSRAND_CHK_BITCNT_EN
  ,
  output logic [23:0]      bit_err_cnt_out
`endif
);

  localparam int RUN_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

  psrand_chk_st_t    st_q, st_n;
  logic [31:0]       pred_q, pred_n;
  logic [RUN_W-1:0]  run_q, run_n;
  logic [MISS_W-1:0] miss_q, miss_n;
  logic [ERR_W-1:0]  err_q, err_n;
  logic [3:0]        mode_d;
  logic              lock_pls_q, lock_pls_n;
  logic              err_pls_q, err_pls_n;
  logic              restart, match;

  // Slot 0 reseeds from the received word, slot 1 flywheels the prediction.
  logic [1:0][31:0]  step_src, step_nxt;

  assign step_src[0] = data_in;
  assign step_src[1] = pred_q;

  for (genvar i = 0; i < 2; i++) begin : g_step
    psrand_step u_step (
      .cur (step_src[i]),
      .nxt (step_nxt[i])
    );
  end

  assign restart = (mode_in == MODE_RAND) && (mode_d != MODE_RAND);
  assign match   = (data_in == pred_q);

`ifdef PSRAND_CHK_BITCNT_EN
  logic [23:0] bit_q, bit_n;
  logic [24:0] bit_sum;
  assign bit_sum = {1'b0, bit_q} + 25'(popcount32(data_in ^ pred_q));
`endif

  always_comb begin
    st_n       = st_q;
    pred_n     = pred_q;
    run_n      = run_q;
    miss_n     = miss_q;
    err_n      = err_q;
    lock_pls_n = 1'b0;
    err_pls_n  = 1'b0;
`ifdef PSRAND_CHK_BITCNT_EN
    bit_n      = bit_q;
`endif
    if (restart) begin
      st_n   = HUNT;
      pred_n = '0;
      run_n  = '0;
      miss_n = '0;
      err_n  = '0;
`ifdef PSRAND_CHK_BITCNT_EN
      bit_n  = '0;
`endif
    end else if (data_vld_in) begin
      case (st_q)
        HUNT: begin
          // An all-zero word is a fixed point of the step and cannot seed.
          if (data_in != '0) begin
            pred_n = step_nxt[0];
            run_n  = '0;
            st_n   = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            pred_n = step_nxt[1];
            if (run_q == RUN_W'(LOCK_CNT - 1)) begin
              st_n       = LOCKED;
              lock_pls_n = 1'b1;
              run_n      = '0;
              miss_n     = '0;
            end else begin
              run_n = run_q + 1'b1;
            end
          end else begin
            pred_n = step_nxt[0];
            run_n  = '0;
          end
        end
        LOCKED: begin
          pred_n = step_nxt[1];
          if (match) begin
            miss_n = '0;
          end else begin
            err_pls_n = 1'b1;
            if (err_q != '1) err_n = err_q + 1'b1;
`ifdef PSRAND_CHK_BITCNT_EN
            bit_n = bit_sum[24] ? '1 : bit_sum[23:0];
`endif
            if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
              st_n   = HUNT;
              miss_n = '0;
            end else begin
              miss_n = miss_q + 1'b1;
            end
          end
        end
        default: st_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st_q       <= HUNT;
      pred_q     <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      err_q      <= '0;
      mode_d     <= '0;
      lock_pls_q <= 1'b0;
      err_pls_q  <= 1'b0;
    end else begin
      st_q       <= st_n;
      pred_q     <= pred_n;
      run_q      <= run_n;
      miss_q     <= miss_n;
      err_q      <= err_n;
      mode_d     <= mode_in;
      lock_pls_q <= lock_pls_n;
      err_pls_q  <= err_pls_n;
    end
  end

`ifdef PSRAND_CHK_BITCNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) bit_q <= '0;
    else        bit_q <= bit_n;
  end
  assign bit_err_cnt_out = bit_q;
`endif

  assign locked_out   = (st_q == LOCKED);
  assign lock_pls_out = lock_pls_q;
  assign err_pls_out  = err_pls_q;
  assign err_cnt_out  = err_q;

endmodule

// File: tb/tb_psrand_chk.sv
// Bench for psrand_chk: directed scenarios plus random traffic against a
// sequence-level reference model, on a default DUT and a LOCK_CNT=1/ERR_W=4 DUT.
module tb_psrand_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mode;
  logic        vld;
  logic [31:0] din;

  logic        locked0, lpls0, epls0, locked1, lpls1, epls1;
  logic [15:0] ecnt0;
  logic [3:0]  ecnt1;
`ifdef PSRAND_CHK_BITCNT_EN
  logic [23:0] bcnt0, bcnt1;
`endif

  always #5 clk = ~clk;

  psrand_chk u_dut0 (
    .clk_in(clk), .rst_in(rst), .mode_in(mode), .data_vld_in(vld), .data_in(din),
    .locked_out(locked0), .lock_pls_out(lpls0), .err_pls_out(epls0), .err_cnt_out(ecnt0)
`ifdef PSRAND_CHK_BITCNT_EN
    , .bit_err_cnt_out(bcnt0)
`endif
  );

  psrand_chk #(.LOCK_CNT(1), .LOSS_CNT(2), .ERR_W(4)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .mode_in(mode), .data_vld_in(vld), .data_in(din),
    .locked_out(locked1), .lock_pls_out(lpls1), .err_pls_out(epls1), .err_cnt_out(ecnt1)
`ifdef PSRAND_CHK_BITCNT_EN
    , .bit_err_cnt_out(bcnt1)
`endif
  );

  // Reference model: tracks what a checker should believe about the stream.
  typedef struct {
    int          st;    // 0 searching, 1 confirming, 2 locked
    logic [31:0] pred;
    int          run;
    int          miss;
    longint      errs;
    longint      bits;
    bit          lock_pls;
    bit          err_pls;
  } mdl_t;

  mdl_t     m[2];
  int       lock_n[2] = '{4, 1};
  int       loss_n[2] = '{3, 2};
  longint   emax[2]   = '{65535, 15};
  logic [3:0] prev_mode;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] gx;
  logic [3:0]  cur_mode;

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ 32'(x * 32'd8192);
    y = y ^ (y / 32'd128);
    y = y ^ 32'(y * 32'd2048);
    return y;
  endfunction

  task automatic mdl_clear();
    for (int k = 0; k < 2; k++) begin
      m[k].st = 0; m[k].pred = '0; m[k].run = 0; m[k].miss = 0;
      m[k].errs = 0; m[k].bits = 0; m[k].lock_pls = 0; m[k].err_pls = 0;
    end
  endtask

  task automatic mdl_apply(input logic [3:0] md, input bit v, input logic [31:0] d);
    bit rs;
    rs = (md == 4'h3) && (prev_mode != 4'h3);
    prev_mode = md;
    for (int k = 0; k < 2; k++) begin
      m[k].lock_pls = 0;
      m[k].err_pls  = 0;
      if (rs) begin
        m[k].st = 0; m[k].pred = '0; m[k].run = 0; m[k].miss = 0;
        m[k].errs = 0; m[k].bits = 0;
      end else if (v) begin
        case (m[k].st)
          0: if (d != 0) begin m[k].pred = ref_step(d); m[k].run = 0; m[k].st = 1; end
          1: begin
            if (d == m[k].pred) begin
              m[k].pred = ref_step(m[k].pred);
              m[k].run++;
              if (m[k].run == lock_n[k]) begin
                m[k].st = 2; m[k].lock_pls = 1; m[k].miss = 0;
              end
            end else begin
              m[k].pred = ref_step(d); m[k].run = 0;
            end
          end
          default: begin
            if (d != m[k].pred) begin
              m[k].err_pls = 1;
              if (m[k].errs < emax[k]) m[k].errs++;
              m[k].bits += $countones(d ^ m[k].pred);
              if (m[k].bits > 64'hFF_FFFF) m[k].bits = 64'hFF_FFFF;
              m[k].miss++;
              if (m[k].miss == loss_n[k]) begin m[k].st = 0; m[k].miss = 0; end
            end else begin
              m[k].miss = 0;
            end
            m[k].pred = ref_step(m[k].pred);
          end
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("locked0", 32'(locked0), 32'(m[0].st == 2));
    chk("lock_pls0", 32'(lpls0), 32'(m[0].lock_pls));
    chk("err_pls0", 32'(epls0), 32'(m[0].err_pls));
    chk("err_cnt0", 32'(ecnt0), 32'(m[0].errs));
    chk("locked1", 32'(locked1), 32'(m[1].st == 2));
    chk("lock_pls1", 32'(lpls1), 32'(m[1].lock_pls));
    chk("err_pls1", 32'(epls1), 32'(m[1].err_pls));
    chk("err_cnt1", 32'(ecnt1), 32'(m[1].errs));
`ifdef PSRAND_CHK_BITCNT_EN
    chk("bit_cnt0", 32'(bcnt0), 32'(m[0].bits));
    chk("bit_cnt1", 32'(bcnt1), 32'(m[1].bits));
`endif
  endtask

  task automatic drive(input logic [3:0] md, input bit v, input logic [31:0] d);
    @(negedge clk);
    mode = md; vld = v; din = d;
    @(posedge clk);
    #1;
    mdl_apply(md, v, d);
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(cur_mode, 1'b0, $urandom);
  endtask

  // Send the next generator word, optionally corrupted, after a gap of idle cycles.
  task automatic send(input int gap, input logic [31:0] flip);
    idle(gap);
    drive(cur_mode, 1'b1, gx ^ flip);
    gx = ref_step(gx);
  endtask

  task automatic restart_hunt();
    drive(4'h0, 1'b0, '0);
    drive(4'h3, 1'b1, $urandom);
    cur_mode = 4'h3;
  endtask

  initial begin
    rst = 1'b1; mode = '0; vld = 1'b0; din = '0;
    cur_mode = '0; prev_mode = '0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    rst = 1'b0;

    // Lock from seed 1 with gapped delivery.
    gx = 32'h1;
    for (int i = 0; i < 5; i++) send($urandom_range(0, 7), '0);
    chk("t1_lock_pls", 32'(lpls0), 32'h1);
    chk("t1_locked", 32'(locked0), 32'h1);
    chk("t1_err", 32'(ecnt0), 32'h0);

    // Single bit-0 corruption while locked, then a clean word.
    send(0, 32'h1);
    chk("t2_err_pls", 32'(epls0), 32'h1);
    chk("t2_err", 32'(ecnt0), 32'h1);
    chk("t2_locked", 32'(locked0), 32'h1);
    send(1, '0);
    chk("t2_flywheel", 32'(epls0), 32'h0);

    // Three consecutive bad words lose lock; clean stream relocks.
    restart_hunt();
    for (int i = 0; i < 5; i++) send(0, '0);
    for (int i = 0; i < 3; i++) send(0, 32'h1 << $urandom_range(0, 31));
    chk("t3_unlock", 32'(locked0), 32'h0);
    chk("t3_err", 32'(ecnt0), 32'h3);
    for (int i = 0; i < 5; i++) send($urandom_range(0, 2), '0);
    chk("t3_relock", 32'(locked0), 32'h1);
    chk("t3_err_kept", 32'(ecnt0), 32'h3);

    // Restart on 0000->0011, word on that cycle discarded; holding 0011 is harmless.
    cur_mode = 4'h0;
    idle(1);
    cur_mode = 4'h3;
    send(0, '0);
    chk("t4_err_clr", 32'(ecnt0), 32'h0);
    chk("t4_unlock", 32'(locked0), 32'h0);
    for (int i = 0; i < 5; i++) send(0, '0);
    chk("t4_hold", 32'(locked0), 32'h1);

    // Zero words never seed.
    restart_hunt();
    for (int i = 0; i < 8; i++) drive(cur_mode, 1'b1, '0);
    chk("t5_zero", 32'(locked0), 32'h0);

    // Gapped delivery reproduces the same lock result.
    for (int r = 0; r < 3; r++) begin
      restart_hunt();
      gx = 32'h1;
      for (int i = 0; i < 5; i++) send($urandom_range(0, 7), '0);
      chk("t5_gap_lock", 32'(locked0), 32'h1);
    end

    // Byte-wide error while locked.
    send(0, 32'hFF00_0000);
    chk("t6_err", 32'(ecnt0), 32'h1);
`ifdef PSRAND_CHK_BITCNT_EN
    chk("t6_bits", 32'(bcnt0), 32'h8);
`endif

    // Narrow counter saturation: lock/loss cycles on the LOCK_CNT=1 instance.
    restart_hunt();
    for (int i = 0; i < 10; i++) begin
      send(0, '0); send(0, '0); send(0, 32'h4); send(0, 32'h4);
    end
    chk("t6_sat", 32'(ecnt1), 32'hF);

    // Random traffic.
    cur_mode = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       begin cur_mode = ($urandom_range(0, 1) != 0) ? 4'h3 : 4'($urandom); idle(0); end
      else if (r < 30) idle(1);
      else if (r < 40) send(0, $urandom | 32'h1);
      else if (r < 43) send(0, 32'hFF00_0000);
      else if (r < 45) gx = $urandom;
      else if (r < 46) drive(cur_mode, 1'b1, '0);
      else             send(0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
